// File: rtl/sr_latch_pkg.sv
// Shared types and default parameter values for the SR latch bank.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SET  = 2'd1,
        MODE_RST  = 2'd2,
        MODE_NOR  = 2'd3
    } mode_t;

    localparam int    DEF_CHANNELS = 2;
    localparam int    DEF_STAGES   = 10;
    localparam int    DEF_CNT_W    = 8;
    localparam mode_t DEF_MODE     = MODE_NOR;

endpackage

// File: rtl/nor_delay_line.sv
// Chain of registered inverting stages; each stage is a NOR gate whose
// second input is tied low, so the chain inverts once per stage.
module nor_delay_line #(
    parameter int STAGES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);

    // Reset pattern matches a chain that has settled with a 0 input.
    function automatic logic [STAGES-1:0] rst_pattern();
        logic [STAGES-1:0] p;
        p = '0;
        for (int k = 0; k < STAGES; k++) p[k] = ~k[0];
        return p;
    endfunction

    localparam logic [STAGES-1:0] RST_PAT = rst_pattern();

    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    always_comb begin
        stage_d    = '0;
        stage_d[0] = ~(in_i | 1'b0);
        for (int k = 1; k < STAGES; k++) stage_d[k] = ~(stage_q[k-1] | 1'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= RST_PAT;
        else     stage_q <= stage_d;
    end

    assign out_o = stage_q[STAGES-1];

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of independent registered SR latches fed through NOR delay chains.
// Optional per-channel conflict counters are built when SR_CONFLICT_CNT_EN is defined.
module sr_latch_bank
    import sr_latch_pkg::*;
#(
    parameter int    CHANNELS = DEF_CHANNELS,
    parameter int    STAGES   = DEF_STAGES,
    parameter mode_t MODE     = DEF_MODE,
    parameter int    CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       set_i,
    input  logic [CHANNELS-1:0]       reset_i,
    input  logic                      clr_cnt_i,
    output logic [CHANNELS-1:0]       q_o,
    output logic [CHANNELS-1:0]       qn_o,
    output logic [CHANNELS-1:0]       conflict_o,
    output logic [CHANNELS-1:0]       meta_o,
    output logic [CHANNELS*CNT_W-1:0] conflict_cnt_o
);

    // An odd chain length leaves the delayed value inverted; undo that here.
    localparam logic ODD_POL = logic'(STAGES % 2);

    logic [CHANNELS-1:0] ds_raw, dr_raw, ds, dr;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chain
        nor_delay_line #(.STAGES(STAGES)) u_set_dly (
            .clk(clk), .rst(rst), .in_i(set_i[ch]), .out_o(ds_raw[ch])
        );
        nor_delay_line #(.STAGES(STAGES)) u_rst_dly (
            .clk(clk), .rst(rst), .in_i(reset_i[ch]), .out_o(dr_raw[ch])
        );
    end

    assign ds = ds_raw ^ {CHANNELS{ODD_POL}};
    assign dr = dr_raw ^ {CHANNELS{ODD_POL}};

    logic [CHANNELS-1:0] q_q, q_d, qn_q, qn_d;
    logic [CHANNELS-1:0] conf_q, conf_d, meta_q, meta_d;
    logic [CHANNELS-1:0] pds_q, pdr_q;

    always_comb begin
        logic both, pboth;
        q_d    = q_q;
        qn_d   = qn_q;
        conf_d = '0;
        meta_d = '0;
        both   = 1'b0;
        pboth  = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            both        = ds[ch] & dr[ch];
            pboth       = pds_q[ch] & pdr_q[ch];
            conf_d[ch]  = both & ~pboth;
            if (ds[ch] && !dr[ch]) begin
                q_d[ch] = 1'b1; qn_d[ch] = 1'b0;
            end else if (dr[ch] && !ds[ch]) begin
                q_d[ch] = 1'b0; qn_d[ch] = 1'b1;
            end else if (both) begin
                case (MODE)
                    MODE_SET: begin q_d[ch] = 1'b1; qn_d[ch] = 1'b0; end
                    MODE_RST: begin q_d[ch] = 1'b0; qn_d[ch] = 1'b1; end
                    MODE_NOR: begin q_d[ch] = 1'b0; qn_d[ch] = 1'b0; end
                    default:  ;
                endcase
            end else if (MODE == MODE_NOR && pboth) begin
                // Simultaneous release from a NOR conflict resolves to reset.
                q_d[ch]    = 1'b0;
                qn_d[ch]   = 1'b1;
                meta_d[ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            qn_q   <= '1;
            conf_q <= '0;
            meta_q <= '0;
            pds_q  <= '0;
            pdr_q  <= '0;
        end else begin
            q_q    <= q_d;
            qn_q   <= qn_d;
            conf_q <= conf_d;
            meta_q <= meta_d;
            pds_q  <= ds;
            pdr_q  <= dr;
        end
    end

    assign q_o        = q_q;
    assign qn_o       = qn_q;
    assign conflict_o = conf_q;
    assign meta_o     = meta_q;

`ifdef SR_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    // Counts advance on the same edge that raises conflict_o.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (clr_cnt_i)                          cnt_d[ch] = '0;
            else if (conf_d[ch] && cnt_q[ch] != '1) cnt_d[ch] = cnt_q[ch] + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= cnt_d[ch];
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cnt_out
        assign conflict_cnt_o[ch*CNT_W +: CNT_W] = cnt_q[ch];
    end
`else
    logic unused_clr;
    assign unused_clr     = clr_cnt_i;
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sr_latch_bank.sv
// Drives five differently configured latch banks with shared directed and
// random stimulus and compares every output against a history-based model.
module tb_sr_latch_bank;
    import sr_latch_pkg::*;

    localparam int NK   = 5;
    localparam int CH   = 2;
    localparam int HMAX = 16;

    int    stg  [NK] = '{10, 3, 4, 4, 1};
    mode_t md   [NK] = '{MODE_NOR, MODE_NOR, MODE_SET, MODE_RST, MODE_HOLD};
    int    cmax [NK] = '{255, 3, 255, 255, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic [CH-1:0] s_in = '0;
    logic [CH-1:0] r_in = '0;

    logic [CH-1:0] q_w [NK];
    logic [CH-1:0] qn_w [NK];
    logic [CH-1:0] cf_w [NK];
    logic [CH-1:0] mt_w [NK];
    logic [15:0]   cnt_a [3];
    logic [3:0]    cnt_b [2];

    int cmp_n  = 0;
    int fail_n = 0;

    always #5 clk = ~clk;

    sr_latch_bank #(.CHANNELS(CH), .STAGES(10), .MODE(MODE_NOR), .CNT_W(8)) u_k0 (
        .clk(clk), .rst(rst), .set_i(s_in), .reset_i(r_in), .clr_cnt_i(clr),
        .q_o(q_w[0]), .qn_o(qn_w[0]), .conflict_o(cf_w[0]), .meta_o(mt_w[0]),
        .conflict_cnt_o(cnt_a[0]));
    sr_latch_bank #(.CHANNELS(CH), .STAGES(3), .MODE(MODE_NOR), .CNT_W(2)) u_k1 (
        .clk(clk), .rst(rst), .set_i(s_in), .reset_i(r_in), .clr_cnt_i(clr),
        .q_o(q_w[1]), .qn_o(qn_w[1]), .conflict_o(cf_w[1]), .meta_o(mt_w[1]),
        .conflict_cnt_o(cnt_b[0]));
    sr_latch_bank #(.CHANNELS(CH), .STAGES(4), .MODE(MODE_SET), .CNT_W(8)) u_k2 (
        .clk(clk), .rst(rst), .set_i(s_in), .reset_i(r_in), .clr_cnt_i(clr),
        .q_o(q_w[2]), .qn_o(qn_w[2]), .conflict_o(cf_w[2]), .meta_o(mt_w[2]),
        .conflict_cnt_o(cnt_a[1]));
    sr_latch_bank #(.CHANNELS(CH), .STAGES(4), .MODE(MODE_RST), .CNT_W(8)) u_k3 (
        .clk(clk), .rst(rst), .set_i(s_in), .reset_i(r_in), .clr_cnt_i(clr),
        .q_o(q_w[3]), .qn_o(qn_w[3]), .conflict_o(cf_w[3]), .meta_o(mt_w[3]),
        .conflict_cnt_o(cnt_a[2]));
    sr_latch_bank #(.CHANNELS(CH), .STAGES(1), .MODE(MODE_HOLD), .CNT_W(2)) u_k4 (
        .clk(clk), .rst(rst), .set_i(s_in), .reset_i(r_in), .clr_cnt_i(clr),
        .q_o(q_w[4]), .qn_o(qn_w[4]), .conflict_o(cf_w[4]), .meta_o(mt_w[4]),
        .conflict_cnt_o(cnt_b[1]));

    // Model: hs/hr[j] hold the inputs sampled j edges ago (0 = this edge).
    bit hs [HMAX][CH];
    bit hr [HMAX][CH];
    bit mq [NK][CH];
    bit mqn [NK][CH];
    bit mcf [NK][CH];
    bit mmt [NK][CH];
    bit mpb [NK][CH];
    int mcnt [NK][CH];

    task automatic model_reset();
        for (int j = 0; j < HMAX; j++)
            for (int c = 0; c < CH; c++) begin hs[j][c] = 0; hr[j][c] = 0; end
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < CH; c++) begin
                mq[k][c] = 0; mqn[k][c] = 1; mcf[k][c] = 0; mmt[k][c] = 0;
                mpb[k][c] = 0; mcnt[k][c] = 0;
            end
    endtask

    task automatic model_edge();
        bit s, r, both;
        if (rst) return;
        for (int j = HMAX - 1; j > 0; j--)
            for (int c = 0; c < CH; c++) begin hs[j][c] = hs[j-1][c]; hr[j][c] = hr[j-1][c]; end
        for (int c = 0; c < CH; c++) begin hs[0][c] = s_in[c]; hr[0][c] = r_in[c]; end
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < CH; c++) begin
                s    = hs[stg[k]][c];
                r    = hr[stg[k]][c];
                both = s && r;
                mcf[k][c] = both && !mpb[k][c];
                mmt[k][c] = 0;
                if (s && !r) begin mq[k][c] = 1; mqn[k][c] = 0; end
                else if (r && !s) begin mq[k][c] = 0; mqn[k][c] = 1; end
                else if (both) begin
                    if (md[k] == MODE_SET) begin mq[k][c] = 1; mqn[k][c] = 0; end
                    else if (md[k] == MODE_RST) begin mq[k][c] = 0; mqn[k][c] = 1; end
                    else if (md[k] == MODE_NOR) begin mq[k][c] = 0; mqn[k][c] = 0; end
                end else if (md[k] == MODE_NOR && mpb[k][c]) begin
                    mq[k][c] = 0; mqn[k][c] = 1; mmt[k][c] = 1;
                end
`ifdef SR_CONFLICT_CNT_EN
                if (clr) mcnt[k][c] = 0;
                else if (mcf[k][c] && mcnt[k][c] < cmax[k]) mcnt[k][c]++;
`endif
                mpb[k][c] = both;
            end
    endtask

    function automatic int get_cnt(int k, int c);
        case (k)
            0: return int'(cnt_a[0][c*8 +: 8]);
            1: return int'(cnt_b[0][c*2 +: 2]);
            2: return int'(cnt_a[1][c*8 +: 8]);
            3: return int'(cnt_a[2][c*8 +: 8]);
            default: return int'(cnt_b[1][c*2 +: 2]);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            fail_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("k%0d c%0d q @%0t", k, c, $time), 32'(q_w[k][c]), 32'(mq[k][c]));
                chk($sformatf("k%0d c%0d qn @%0t", k, c, $time), 32'(qn_w[k][c]), 32'(mqn[k][c]));
                chk($sformatf("k%0d c%0d conflict @%0t", k, c, $time), 32'(cf_w[k][c]), 32'(mcf[k][c]));
                chk($sformatf("k%0d c%0d meta @%0t", k, c, $time), 32'(mt_w[k][c]), 32'(mmt[k][c]));
                chk($sformatf("k%0d c%0d cnt @%0t", k, c, $time), 32'(get_cnt(k, c)), 32'(mcnt[k][c]));
            end
    endtask

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        model_reset();
        #7;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: no spurious pulses, odd chain included.
        tick(20);

        // Three-cycle set pulse on channel 0, latched and held.
        s_in = 2'b01; tick(3);
        s_in = 2'b00; tick(14);

        // Sustained NOR conflict on channel 0 with simultaneous release.
        s_in = 2'b01; r_in = 2'b01; tick(5);
        s_in = 2'b00; r_in = 2'b00; tick(14);

        // Overlapping set/reset, staggered release.
        s_in = 2'b01; tick(2);
        r_in = 2'b01; tick(3);
        s_in = 2'b00; tick(2);
        r_in = 2'b00; tick(14);

        // Five separate conflicts on channel 1 to saturate the narrow counters.
        for (int n = 0; n < 5; n++) begin
            s_in = 2'b10; r_in = 2'b10; tick(2);
            s_in = 2'b00; r_in = 2'b00; tick(3);
        end
        tick(12);

        // Sixth conflict with a clear landing on the edge the STAGES=3 bank sees it.
        s_in = 2'b10; r_in = 2'b10; tick(2);
        s_in = 2'b00; r_in = 2'b00; tick(1);
        clr = 1'b1; tick(1);
        clr = 1'b0; tick(14);

        // Random traffic with occasional counter clears.
        for (int i = 0; i < 250; i++) begin
            s_in = CH'($urandom_range(0, 3));
            r_in = CH'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        s_in = '0; r_in = '0; clr = 1'b0;
        tick(14);

        // Asynchronous reset with channel 0 set and channel 1 mid-conflict.
        s_in = 2'b01; tick(2);
        s_in = 2'b10; r_in = 2'b10; tick(13);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        tick(1);
        s_in = '0; r_in = '0; rst = 1'b0;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank.md
SR_LATCH_BANK -- requirements
Module: sr_latch_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, number of independent latch channels (>=1).
REQ-002 The block SHALL have parameter STAGES, default 10, number of registered NOR delay stages per input (>=1).
REQ-003 The block SHALL have parameter MODE, default MODE_NOR, conflict policy per sr_latch_pkg::mode_t.
REQ-004 The block SHALL have parameter CNT_W, default 8, width of each conflict counter.
REQ-005 The block SHALL have port clk  input  1  the single clock, all state rising-edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port set_i  input  CHANNELS  per-channel set request.
REQ-008 The block SHALL have port reset_i  input  CHANNELS  per-channel reset request.
REQ-009 The block SHALL have port clr_cnt_i  input  1  synchronous clear of all conflict counters.
REQ-010 The block SHALL have port q_o  output  CHANNELS  latch output Q.
REQ-011 The block SHALL have port qn_o  output  CHANNELS  latch output Q-not.
REQ-012 The block SHALL have port conflict_o  output  CHANNELS  one-cycle pulse on conflict entry.
REQ-013 The block SHALL have port meta_o  output  CHANNELS  one-cycle pulse on simultaneous release from conflict.
REQ-014 The block SHALL have port conflict_cnt_o  output  CHANNELS*CNT_W  per-channel conflict counts, channel 0 in LSBs.

Function
REQ-015 Each input SHALL pass through STAGES registered inverting stages; delayed value = input delayed STAGES cycles, inverted iff STAGES odd.
REQ-016 Latch state SHALL be registered; a delayed-input change is visible on q_o/qn_o at edge STAGES+1 after the input edge.
REQ-017 Delayed set only -> q=1,qn=0; delayed reset only -> q=0,qn=1; neither -> hold.
REQ-018 Both asserted, MODE_HOLD -> hold; MODE_SET -> q=1,qn=0; MODE_RST -> q=0,qn=1.
REQ-019 Both asserted, MODE_NOR -> q=0,qn=0 for the entire conflict.
REQ-020 MODE_NOR exit: one input releases first -> remaining asserted input sets the state; both release in the same cycle -> q=0,qn=1 and meta_o pulses for one cycle.
REQ-021 Outside MODE_NOR, q_o SHALL always equal ~qn_o, and meta_o SHALL stay 0.
REQ-022 conflict_o SHALL pulse one cycle when the delayed pair transitions into both-asserted; a sustained conflict counts once.
REQ-023 Counters SHALL increment on conflict_o and saturate at 2^CNT_W-1 (no wrap).
REQ-024 clr_cnt_i SHALL zero all counters next edge; clr_cnt_i wins over a same-cycle increment.
REQ-025 Channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-026 rst SHALL asynchronously force: delay stages to the values consistent with a 0 input (alternating 1,0,... from stage 0), q_o=0, qn_o=1, conflict_o=0, meta_o=0, counters=0.
REQ-027 Reset asserted mid-conflict or mid-propagation SHALL discard all in-flight pulses; no conflict_o or meta_o pulse SHALL occur on reset release.

Configuration
REQ-028 With SR_CONFLICT_CNT_EN defined, counters SHALL be implemented per REQ-023/024.
REQ-029 Without SR_CONFLICT_CNT_EN, conflict_cnt_o SHALL be tied to 0, clr_cnt_i SHALL be ignored, and no counter flops SHALL exist; conflict_o and meta_o are unaffected.

Structure
REQ-030 Package sr_latch_pkg SHALL hold typedef mode_t (MODE_HOLD, MODE_SET, MODE_RST, MODE_NOR) and default parameter constants.
REQ-031 Sub-module nor_delay_line (parameter STAGES) SHALL implement one inverting delay chain and be instantiated 2*CHANNELS times.

Verification
REQ-032 STAGES=10, MODE_NOR: set_i[0] pulse of 3 cycles at cycle 5 -> q_o[0]=1 from cycle 16, held after the pulse ends.
REQ-033 STAGES=3 (odd): after reset with inputs 0 -> q_o=0, qn_o=1, no spurious pulses for 20 cycles.
REQ-034 MODE_NOR: set_i and reset_i both high for cycles 10-14, both low at 15 -> q=qn=0 during conflict, then q=0,qn=1, meta_o one pulse, conflict_o one pulse, count=1.
REQ-035 MODE_SET vs MODE_RST with identical overlapping stimulus -> q=1 and q=0 respectively during overlap; meta_o never pulses.
REQ-036 CNT_W=2: 5 separate conflicts -> count saturates at 3; clr_cnt_i coincident with the 6th conflict -> count 0.
REQ-037 rst asserted asynchronously mid-conflict in channel 1 with channel 0 at q=1 -> all outputs at reset values immediately, no pulses after release.
